spi_cmd_decoder: RTL and testbench

//  Front-end command parser of top_raster_system, between the quad-SPI nybble receiver and the vert/tri/inst buffers.

---
 rtl/spi_cmd_decoder.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// Command parser between the quad-SPI nybble receiver and the vertex/triangle/instance buffers.
// Checks the zero-padded header, reads the arguments and emits whole payload records on a valid/ready port.
module spi_cmd_decoder #(
  parameter int VTX_W   = 108,
  parameter int IDX_W   = 8,
  parameter int TRANS_W = 384,
  parameter int HDR_NYB = 8
) (
  input  logic                 clk_100m,
  input  logic                 rst_n,
  input  logic                 cs_active,
  input  logic                 nyb_valid,
  input  logic [3:0]           nyb_data,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [1:0]           rec_type,
  output logic [IDX_W-1:0]     rec_idx,
  output logic [2*IDX_W-1:0]   rec_aux,
  output logic [TRANS_W-1:0]   rec_data,
  output logic                 cmd_done,
  output logic                 busy,
  output logic [3:0]           err_code
);

  // Opcode encoding shared with the host-side command builder
  localparam logic [3:0] OP_CREATE_VERT = 4'h1;
  localparam logic [3:0] OP_CREATE_TRI  = 4'h2;
  localparam logic [3:0] OP_CREATE_INST = 4'h3;
  localparam logic [3:0] OP_UPDATE_INST = 4'h4;

  localparam logic [3:0] ERR_PAD       = 4'd1;
  localparam logic [3:0] ERR_OPCODE    = 4'd2;
  localparam logic [3:0] ERR_TRUNCATED = 4'd3;
  localparam logic [3:0] ERR_OVERFLOW  = 4'd4;

  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_NYB);
  localparam logic [CNT_W-1:0] ARG1_LAST = CNT_W'(IDX_W/4 - 1);
  localparam logic [CNT_W-1:0] ARG2_LAST = CNT_W'(2*IDX_W/4 - 1);
  localparam logic [CNT_W-1:0] VERT_LAST = CNT_W'(VTX_W/4 - 1);
  localparam logic [CNT_W-1:0] TRI_LAST  = CNT_W'(3*IDX_W/4 - 1);
  localparam logic [CNT_W-1:0] INST_LAST = CNT_W'(TRANS_W/4 - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_ARG     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DONE    = 3'd4,
    S_ERR     = 3'd5
  } state_t;

  function automatic logic is_known_op(input logic [3:0] op);
    is_known_op = (op == OP_CREATE_VERT) || (op == OP_CREATE_TRI) ||
                  (op == OP_CREATE_INST) || (op == OP_UPDATE_INST);
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_cs_d;
  logic [CNT_W-1:0]      r_cnt;
  logic [TRANS_W-5:0]    r_sh;
  logic [3:0]            r_op;
  logic [IDX_W-1:0]      r_count;
  logic [IDX_W-1:0]      r_rec_cnt;
  logic [2*IDX_W-1:0]    r_aux;

  logic                  r_rec_valid;
  logic [1:0]            r_rec_type;
  logic [IDX_W-1:0]      r_rec_idx;
  logic [2*IDX_W-1:0]    r_rec_aux;
  logic [TRANS_W-1:0]    r_rec_data;
  logic                  r_cmd_done;
  logic                  r_busy;
  logic [3:0]            r_err;

  logic                  w_acc;
  logic [TRANS_W-1:0]    w_shift;
  logic [CNT_W-1:0]      w_rec_last;
  logic [CNT_W-1:0]      w_arg_last;
  logic [1:0]            w_rec_type;
  logic                  w_is_inst;
  logic [2*IDX_W-1:0]    w_aux_nxt;
  logic                  w_last_rec;
  logic                  w_count_zero;

  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_sh_clr;
  logic                  w_sh_load;
  logic                  w_op_load;
  logic                  w_arg_done;
  logic                  w_rec_load;
  logic                  w_err_clr;
  logic                  w_err_set;
  logic [3:0]            w_err_val;

  assign w_acc        = nyb_valid & cs_active;
  assign w_shift      = {r_sh, nyb_data};
  assign w_last_rec   = w_is_inst | (r_rec_cnt == (r_count - IDX_W'(1)));
  assign w_count_zero = (w_shift[IDX_W-1:0] == {IDX_W{1'b0}});

  // Per-opcode record geometry, record type and argument decode
  always_comb begin
    w_rec_last = INST_LAST;
    w_arg_last = ARG1_LAST;
    w_rec_type = 2'd0;
    w_is_inst  = 1'b0;
    w_aux_nxt  = {(2*IDX_W){1'b0}};
    case (r_op)
      OP_CREATE_VERT: begin
        w_rec_last = VERT_LAST;
        w_rec_type = 2'd0;
      end
      OP_CREATE_TRI: begin
        w_rec_last = TRI_LAST;
        w_rec_type = 2'd1;
      end
      OP_CREATE_INST: begin
        w_arg_last = ARG2_LAST;
        w_rec_type = 2'd2;
        w_is_inst  = 1'b1;
        w_aux_nxt  = w_shift[2*IDX_W-1:0];
      end
      OP_UPDATE_INST: begin
        w_rec_type = 2'd3;
        w_is_inst  = 1'b1;
        w_aux_nxt  = {{IDX_W{1'b0}}, w_shift[IDX_W-1:0]};
      end
      default: begin
        w_rec_last = INST_LAST;
      end
    endcase
  end

  // Next-state and datapath control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_sh_clr    = 1'b0;
    w_sh_load   = 1'b0;
    w_op_load   = 1'b0;
    w_arg_done  = 1'b0;
    w_rec_load  = 1'b0;
    w_err_clr   = 1'b0;
    w_err_set   = 1'b0;
    w_err_val   = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (cs_active && !r_cs_d) begin
          w_state_nxt = S_HDR;
          w_err_clr   = 1'b1;
          w_cnt_clr   = 1'b1;
          w_sh_clr    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HDR: begin
        if (!cs_active) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
          w_err_val   = ERR_TRUNCATED;
        end else if (w_acc) begin
          if (r_cnt != HDR_LAST) begin
            if (nyb_data != 4'h0) begin
              w_state_nxt = S_ERR;
              w_err_set   = 1'b1;
              w_err_val   = ERR_PAD;
            end else begin
              w_cnt_inc = 1'b1;
            end
          end else if (is_known_op(nyb_data)) begin
            w_state_nxt = S_ARG;
            w_op_load   = 1'b1;
            w_cnt_clr   = 1'b1;
          end else begin
            w_state_nxt = S_ERR;
            w_err_set   = 1'b1;
            w_err_val   = ERR_OPCODE;
          end
        end else begin
          w_state_nxt = S_HDR;
        end
      end
      S_ARG: begin
        if (!cs_active) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
          w_err_val   = ERR_TRUNCATED;
        end else if (w_acc) begin
          if (r_cnt == w_arg_last) begin
            w_arg_done = 1'b1;
            w_cnt_clr  = 1'b1;
            w_sh_clr   = 1'b1;
            // An empty vertex/triangle list completes the command immediately
            if (!w_is_inst && w_count_zero) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_PAYLOAD;
            end
          end else begin
            w_cnt_inc = 1'b1;
            w_sh_load = 1'b1;
          end
        end else begin
          w_state_nxt = S_ARG;
        end
      end
      S_PAYLOAD: begin
        if (!cs_active) begin
          w_state_nxt = S_IDLE;
          w_err_set   = 1'b1;
          w_err_val   = ERR_TRUNCATED;
        end else if (w_acc) begin
          if (r_cnt == w_rec_last) begin
            w_cnt_clr = 1'b1;
            w_sh_clr  = 1'b1;
            if (r_rec_valid && !rec_ready) begin
              w_state_nxt = S_ERR;
              w_err_set   = 1'b1;
              w_err_val   = ERR_OVERFLOW;
            end else begin
              w_rec_load = 1'b1;
              if (w_last_rec) begin
                w_state_nxt = S_DONE;
              end else begin
                w_state_nxt = S_PAYLOAD;
              end
            end
          end else begin
            w_cnt_inc = 1'b1;
            w_sh_load = 1'b1;
          end
        end else begin
          w_state_nxt = S_PAYLOAD;
        end
      end
      S_DONE, S_ERR: begin
        if (!cs_active) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Nybble counter, shift register and per-command context
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_d    <= 1'b0;
      r_cnt     <= '0;
      r_sh      <= '0;
      r_op      <= 4'h0;
      r_count   <= '0;
      r_rec_cnt <= '0;
      r_aux     <= '0;
    end else begin
      r_cs_d <= cs_active;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_sh_clr) begin
        r_sh <= '0;
      end else if (w_sh_load) begin
        r_sh <= w_shift[TRANS_W-5:0];
      end
      if (w_op_load) begin
        r_op <= nyb_data;
      end
      if (w_arg_done) begin
        r_count   <= w_shift[IDX_W-1:0];
        r_aux     <= w_aux_nxt;
        r_rec_cnt <= '0;
      end else if (w_rec_load) begin
        r_rec_cnt <= r_rec_cnt + IDX_W'(1);
      end
    end
  end

  // Record output register; a load in the handshake cycle keeps valid high
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_rec_valid <= 1'b0;
      r_rec_type  <= 2'd0;
      r_rec_idx   <= '0;
      r_rec_aux   <= '0;
      r_rec_data  <= '0;
    end else if (w_rec_load) begin
      r_rec_valid <= 1'b1;
      r_rec_type  <= w_rec_type;
      r_rec_idx   <= w_is_inst ? {IDX_W{1'b0}} : r_rec_cnt;
      r_rec_aux   <= r_aux;
      r_rec_data  <= w_shift;
    end else if (r_rec_valid && rec_ready) begin
      r_rec_valid <= 1'b0;
    end
  end

  // Status outputs: done pulse, busy flag and sticky error code
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_done <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 4'd0;
    end else begin
      r_cmd_done <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_err_clr) begin
        r_err <= 4'd0;
      end else if (w_err_set) begin
        r_err <= w_err_val;
      end
    end
  end

  assign rec_valid = r_rec_valid;
  assign rec_type  = r_rec_type;
  assign rec_idx   = r_rec_idx;
  assign rec_aux   = r_rec_aux;
  assign rec_data  = r_rec_data;
  assign cmd_done  = r_cmd_done;
  assign busy      = r_busy;
  assign err_code  = r_err;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: directed commands push expected records,
// a monitor pops and compares on every accepted record.
module tb_spi_cmd_decoder;
  localparam int IDX_W   = 8;
  localparam int TRANS_W = 384;

  logic                 clk_100m  = 1'b0;
  logic                 rst_n     = 1'b0;
  logic                 cs_active = 1'b0;
  logic                 nyb_valid = 1'b0;
  logic [3:0]           nyb_data  = 4'h0;
  logic                 rec_ready = 1'b1;
  logic                 rec_valid;
  logic [1:0]           rec_type;
  logic [IDX_W-1:0]     rec_idx;
  logic [2*IDX_W-1:0]   rec_aux;
  logic [TRANS_W-1:0]   rec_data;
  logic                 cmd_done;
  logic                 busy;
  logic [3:0]           err_code;

  spi_cmd_decoder dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .cs_active(cs_active),
    .nyb_valid(nyb_valid),
    .nyb_data (nyb_data),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_type (rec_type),
    .rec_idx  (rec_idx),
    .rec_aux  (rec_aux),
    .rec_data (rec_data),
    .cmd_done (cmd_done),
    .busy     (busy),
    .err_code (err_code)
  );

  always #5 clk_100m = ~clk_100m;

  typedef struct {
    logic [1:0]   typ;
    logic [7:0]   idx;
    logic [15:0]  aux;
    logic [383:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   d0;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] t, input logic [7:0] idx,
                          input logic [15:0] aux, input logic [383:0] d);
    exp_t e;
    e.typ = t; e.idx = idx; e.aux = aux; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every accepted record and count done pulses
  always @(negedge clk_100m) begin
    if (rst_n) begin
      if (cmd_done) n_done++;
      if (rec_valid && rec_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_record: got type %0d idx %0d data %0h, none expected",
                   rec_type, rec_idx, rec_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rec_type", 384'(rec_type), 384'(e.typ));
          chk("rec_idx",  384'(rec_idx),  384'(e.idx));
          chk("rec_aux",  384'(rec_aux),  384'(e.aux));
          chk("rec_data", rec_data, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic send_nyb(input logic [3:0] n);
    nyb_valid = 1'b1;
    nyb_data  = n;
    cyc();
    nyb_valid = 1'b0;
    nyb_data  = 4'h0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nyb(b[7:4]);
    send_nyb(b[3:0]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) send_nyb(w[i*4 +: 4]);
  endtask

  task automatic start_cmd(input logic [3:0] op);
    cs_active = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) send_nyb(4'h0);
    send_nyb(op);
  endtask

  task automatic end_cmd();
    cs_active = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic send_vert(input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] z, input logic [11:0] c);
    send_word(x); send_word(y); send_word(z);
    send_nyb(c[11:8]); send_nyb(c[7:4]); send_nyb(c[3:0]);
  endtask

  function automatic logic [383:0] vdat(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z, input logic [11:0] c);
    logic [383:0] d;
    d = 384'h0;
    d[107:0] = {x, y, z, c};
    return d;
  endfunction

  // pos = 0, sin = 0, cos = 1.0, scale = (1,2,3)
  task automatic send_xform();
    for (int i = 0; i < 6; i++) send_word(32'h0000_0000);
    for (int i = 0; i < 3; i++) send_word(32'h0001_0000);
    send_word(32'h0001_0000); send_word(32'h0002_0000); send_word(32'h0003_0000);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc();
    chk(name, 384'(exp_q.size()), 384'd0);
  endtask

  logic [383:0] xform_d;
  logic [383:0] v0_d;

  initial begin
    xform_d = {96'h0, 96'h0, {3{32'h0001_0000}}, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000};

    // Reset state
    repeat (3) cyc();
    chk("rst_outputs", 384'({rec_valid, rec_type, rec_idx, rec_aux, cmd_done, busy, err_code}), 384'd0);
    chk("rst_rec_data", rec_data, 384'd0);
    rst_n = 1'b1;
    cyc();

    // 1) three vertices
    d0 = n_done;
    push_exp(2'd0, 8'd0, 16'h0, vdat(32'h0, 32'h0, 32'h0, 12'hAAA));
    push_exp(2'd0, 8'd1, 16'h0, vdat(32'h0, 32'h0002_0000, 32'h0, 12'hBBB));
    push_exp(2'd0, 8'd2, 16'h0, vdat(32'h0, 32'h0, 32'h0002_0000, 12'hCCC));
    start_cmd(4'h1);
    chk("t1_busy_hdr", 384'(busy), 384'd1);
    send_byte(8'd3);
    send_vert(32'h0, 32'h0, 32'h0, 12'hAAA);
    send_vert(32'h0, 32'h0002_0000, 32'h0, 12'hBBB);
    send_vert(32'h0, 32'h0, 32'h0002_0000, 12'hCCC);
    drain("t1_drain");
    chk("t1_err", 384'(err_code), 384'd0);
    chk("t1_busy_done", 384'(busy), 384'd1);
    end_cmd();
    chk("t1_busy_idle", 384'(busy), 384'd0);
    chk("t1_cmd_done", 384'(n_done - d0), 384'd1);

    // 2) one triangle
    d0 = n_done;
    push_exp(2'd1, 8'd0, 16'h0, 384'h000102);
    start_cmd(4'h2);
    send_byte(8'd1);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
    drain("t2_drain");
    end_cmd();
    chk("t2_cmd_done", 384'(n_done - d0), 384'd1);

    // 3) create instance, then two updates
    d0 = n_done;
    push_exp(2'd2, 8'd0, 16'h0000, xform_d);
    start_cmd(4'h3);
    send_byte(8'h00); send_byte(8'h00);
    send_xform();
    drain("t3_create_drain");
    end_cmd();
    push_exp(2'd3, 8'd0, 16'h0000, xform_d);
    start_cmd(4'h4);
    send_byte(8'h00);
    send_xform();
    drain("t3_update_drain");
    end_cmd();
    push_exp(2'd2, 8'd0, 16'h0307, xform_d);
    start_cmd(4'h3);
    send_byte(8'h03); send_byte(8'h07);
    send_xform();
    drain("t3_create_ids_drain");
    end_cmd();
    push_exp(2'd3, 8'd0, 16'h0005, xform_d);
    start_cmd(4'h4);
    send_byte(8'h05);
    send_xform();
    drain("t3_update_id_drain");
    end_cmd();
    chk("t3_cmd_done", 384'(n_done - d0), 384'd4);

    // 4) back-pressure: second record overflows
    d0 = n_done;
    rec_ready = 1'b0;
    v0_d = vdat(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 12'h5A5);
    push_exp(2'd0, 8'd0, 16'h0, v0_d);
    start_cmd(4'h1);
    send_byte(8'd2);
    send_vert(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 12'h5A5);
    repeat (3) cyc();
    chk("t4_held_valid", 384'(rec_valid), 384'd1);
    chk("t4_held_data", rec_data, v0_d);
    send_vert(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 12'h444);
    cyc();
    chk("t4_err_overflow", 384'(err_code), 384'd4);
    chk("t4_still_data", rec_data, v0_d);
    chk("t4_still_idx", 384'(rec_idx), 384'd0);
    rec_ready = 1'b1;
    drain("t4_drain");
    chk("t4_no_cmd_done", 384'(n_done - d0), 384'd0);
    end_cmd();

    // 5) truncated vertex, then error cleared by next transaction
    d0 = n_done;
    start_cmd(4'h1);
    send_byte(8'd1);
    for (int i = 0; i < 10; i++) send_nyb(4'h7);
    cs_active = 1'b0;
    cyc();
    chk("t5_busy_low", 384'(busy), 384'd0);
    chk("t5_err_trunc", 384'(err_code), 384'd3);
    cs_active = 1'b1;
    cyc();
    chk("t5_err_cleared", 384'(err_code), 384'd0);
    chk("t5_busy_again", 384'(busy), 384'd1);
    for (int i = 0; i < 8; i++) send_nyb(4'h0);
    send_nyb(4'h2);
    send_byte(8'd1);
    push_exp(2'd1, 8'd0, 16'h0, 384'hA0B0C0);
    send_byte(8'hA0); send_byte(8'hB0); send_byte(8'hC0);
    drain("t5_drain");
    end_cmd();
    chk("t5_cmd_done", 384'(n_done - d0), 384'd1);

    // 6a) nonzero pad nybble
    cs_active = 1'b1;
    cyc();
    send_nyb(4'h0); send_nyb(4'h0); send_nyb(4'h0); send_nyb(4'h5);
    chk("t6_err_pad", 384'(err_code), 384'd1);
    for (int i = 0; i < 6; i++) send_nyb(4'h1);
    chk("t6_busy_err", 384'(busy), 384'd1);
    end_cmd();
    chk("t6_err_sticky", 384'(err_code), 384'd1);

    // 6b) unknown opcode
    start_cmd(4'hF);
    chk("t6_err_opcode", 384'(err_code), 384'd2);
    end_cmd();

    // 6c) count 0
    d0 = n_done;
    start_cmd(4'h1);
    send_byte(8'd0);
    cyc();
    chk("t6_count0_done", 384'(n_done - d0), 384'd1);
    chk("t6_count0_norec", 384'(rec_valid), 384'd0);
    chk("t6_count0_err", 384'(err_code), 384'd0);
    end_cmd();

    // 6d) count 255 triangles: idx 0..254
    d0 = n_done;
    start_cmd(4'h2);
    send_byte(8'hFF);
    for (int i = 0; i < 255; i++) begin
      logic [7:0] a;
      logic [383:0] d;
      a = 8'(i);
      d = 384'h0;
      d[23:0] = {a, a + 8'd1, a + 8'd2};
      push_exp(2'd1, a, 16'h0, d);
      send_byte(a); send_byte(a + 8'd1); send_byte(a + 8'd2);
    end
    drain("t6_255_drain");
    chk("t6_255_done", 384'(n_done - d0), 384'd1);
    end_cmd();

    // 6e) reset in the middle of a payload
    rec_ready = 1'b0;
    start_cmd(4'h1);
    send_byte(8'd2);
    send_vert(32'hDEAD_BEEF, 32'h0, 32'h1, 12'hABC);
    chk("t6_pre_reset_valid", 384'(rec_valid), 384'd1);
    for (int i = 0; i < 5; i++) send_nyb(4'h9);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_outputs", 384'({rec_valid, rec_type, rec_idx, rec_aux, cmd_done, busy, err_code}), 384'd0);
    chk("t6_reset_data", rec_data, 384'd0);
    cs_active = 1'b0;
    cyc();
    rst_n = 1'b1;
    rec_ready = 1'b1;
    repeat (3) cyc();
    chk("t6_after_reset_idle", 384'({rec_valid, busy}), 384'd0);
    chk("t6_queue_empty", 384'(exp_q.size()), 384'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
